// File: rtl/mem16_pkg.sv
// Shared types for the cpu16 memory arbiter.
package mem16_pkg;

  localparam int unsigned STARVE_W = 4;

  // Which requester owns the SRAM read/write that returns in the next cycle.
  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_INS    = 2'd1,
    OWN_DAT_RD = 2'd2,
    OWN_DAT_WR = 2'd3
  } owner_t;

endpackage

// File: rtl/arb2_starve.sv
// Two-input fixed-priority picker (hi wins) with a starvation guard that
// hands the grant to lo after STARVE_MAX consecutive lost arbitrations.
module arb2_starve
  import mem16_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic hi_req,
  input  logic lo_req,
  output logic hi_gnt,
  output logic lo_gnt,
  output logic force_lo
);

  localparam logic [STARVE_W-1:0] StarveLim = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_q;

  // Grant decode: a saturated starve count overrides the hi priority.
  always_comb begin
    force_lo = lo_req && (starve_q == StarveLim);
    lo_gnt   = lo_req && (force_lo || !hi_req);
    hi_gnt   = hi_req && !force_lo;
  end

  // Count consecutive lost arbitrations of lo; any lo grant or idle lo clears.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else if (lo_req && !lo_gnt) begin
      if (starve_q != StarveLim) begin
        starve_q <= starve_q + STARVE_W'(1);
      end
    end else begin
      starve_q <= '0;
    end
  end

endmodule

// File: rtl/mem_arb16.sv
// Arbitrates the cpu16 fetch and data ports onto one single-port SRAM with
// 1-cycle read latency. Data has priority; fetch is protected from starvation.
module mem_arb16
  import mem16_pkg::*;
#(
  parameter int unsigned AW         = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] ins_addr,
  input  logic          ins_req,
  output logic [15:0]   ins_rdata,
  output logic          ins_rdy,
  input  logic [AW-1:0] dat_addr,
  input  logic [15:0]   dat_wdata,
  input  logic          dat_rd_req,
  input  logic          dat_wr_req,
  output logic [15:0]   dat_rdata,
  output logic          dat_rd_rdy,
  output logic          dat_wr_rdy,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  output logic          mem_en,
  output logic          mem_we,
  input  logic [15:0]   mem_rdata,
  output logic [15:0]   ins_stall_cnt,
  output logic          err_dual_req
);

  logic   dat_req, ins_req_g;
  logic   hi_gnt, lo_gnt, force_lo;
  owner_t win, owner_q;
  logic [15:0] stall_q;
  logic        err_q;

  // Requests are gated by reset so nothing is granted (or written) in reset.
  // No pending-grant mask is needed: a grant in cycle N always produces rdy in
  // N+1, so any request seen in N+1 is already the requester's next one.
  assign dat_req   = reset_n & (dat_rd_req | dat_wr_req);
  assign ins_req_g = reset_n & ins_req;

  arb2_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .hi_req  (dat_req),
    .lo_req  (ins_req_g),
    .hi_gnt  (hi_gnt),
    .lo_gnt  (lo_gnt),
    .force_lo(force_lo)
  );

  // Winner decode; on a dual data request the write wins and the read is dropped.
  always_comb begin
    win = OWN_NONE;
    if (force_lo) begin
      win = OWN_INS;
    end else if (hi_gnt && dat_wr_req) begin
      win = OWN_DAT_WR;
    end else if (hi_gnt) begin
      win = OWN_DAT_RD;
    end else if (lo_gnt) begin
      win = OWN_INS;
    end
  end

  // SRAM command mux; all fields idle at zero when nothing is granted.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (win)
      OWN_INS: begin
        mem_en   = 1'b1;
        mem_addr = ins_addr;
      end
      OWN_DAT_RD: begin
        mem_en   = 1'b1;
        mem_addr = dat_addr;
      end
      OWN_DAT_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = dat_addr;
        mem_wdata = dat_wdata;
      end
      default: ;
    endcase
  end

  // Owner register: who gets the SRAM response in the next cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= win;
    end
  end

  // Stall counter (saturating) and sticky dual-request flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (ins_req && !lo_gnt && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      if (dat_rd_req && dat_wr_req) begin
        err_q <= 1'b1;
      end
    end
  end

  assign ins_rdy       = (owner_q == OWN_INS);
  assign dat_rd_rdy    = (owner_q == OWN_DAT_RD);
  assign dat_wr_rdy    = (owner_q == OWN_DAT_WR);
  assign ins_rdata     = ins_rdy ? mem_rdata : 16'h0000;
  assign dat_rdata     = dat_rd_rdy ? mem_rdata : 16'h0000;
  assign ins_stall_cnt = stall_q;
  assign err_dual_req  = err_q;

endmodule

// File: tb/tb_mem_arb16.sv
// Scoreboard bench for mem_arb16: scripted/random requesters, a behavioural
// SRAM, a reference model of the arbitration rules and a decoupled monitor.
module tb_mem_arb16;

  localparam int unsigned SMAX     = 4;
  localparam int unsigned SAT_SMAX = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, sat_rst_n;
  logic [15:0] ins_addr, dat_addr, dat_wdata;
  logic        ins_req, dat_rd_req, dat_wr_req;
  logic [15:0] ins_rdata, dat_rdata, mem_addr, mem_wdata, mem_rdata, ins_stall_cnt;
  logic        ins_rdy, dat_rd_rdy, dat_wr_rdy, mem_en, mem_we, err_dual_req;

  // Second instance used only for the long saturation run.
  logic [15:0] s_ins_rdata, s_dat_rdata, s_mem_addr, s_mem_wdata, s_stall_cnt;
  logic        s_ins_rdy, s_dat_rd_rdy, s_dat_wr_rdy, s_mem_en, s_mem_we, s_err;

  mem_arb16 #(.AW(16), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .ins_addr(ins_addr), .ins_req(ins_req), .ins_rdata(ins_rdata), .ins_rdy(ins_rdy),
    .dat_addr(dat_addr), .dat_wdata(dat_wdata), .dat_rd_req(dat_rd_req),
    .dat_wr_req(dat_wr_req), .dat_rdata(dat_rdata), .dat_rd_rdy(dat_rd_rdy),
    .dat_wr_rdy(dat_wr_rdy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .ins_stall_cnt(ins_stall_cnt), .err_dual_req(err_dual_req)
  );

  mem_arb16 #(.AW(16), .STARVE_MAX(SAT_SMAX)) dut_sat (
    .clk(clk), .reset_n(sat_rst_n),
    .ins_addr(16'h0001), .ins_req(1'b1), .ins_rdata(s_ins_rdata), .ins_rdy(s_ins_rdy),
    .dat_addr(16'h0002), .dat_wdata(16'h0000), .dat_rd_req(1'b1),
    .dat_wr_req(1'b0), .dat_rdata(s_dat_rdata), .dat_rd_rdy(s_dat_rd_rdy),
    .dat_wr_rdy(s_dat_wr_rdy), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_rdata(16'h0000),
    .ins_stall_cnt(s_stall_cnt), .err_dual_req(s_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=done t=%0t", name, $time);
  endtask

  // Behavioural SRAM plus the bench's own shadow copy of its contents.
  logic [15:0] sram   [0:65535];
  logic [15:0] shadow [0:65535];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] = mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Requester scripts; op: 0 idle, 1 read, 2 write, 3 read+write together.
  typedef struct { bit idle; logic [15:0] addr; } ins_item_t;
  typedef struct { int op; logic [15:0] addr; logic [15:0] data; } dat_item_t;
  typedef struct { int cyc; logic [15:0] data; } exp_t;

  ins_item_t ins_script[$];
  dat_item_t dat_script[$];
  exp_t      exp_q[3][$];  // 0 fetch, 1 data read, 2 data write
  bit        ins_pend = 0;
  bit        dat_pend = 0;

  // Driver: a requester holds its request until the model says it was granted.
  always @(posedge clk) begin
    ins_item_t it;
    dat_item_t d;
    #1;
    if (!ins_pend) begin
      ins_req = 1'b0;
      if (ins_script.size() > 0) begin
        it = ins_script.pop_front();
        if (!it.idle) begin
          ins_req  = 1'b1;
          ins_addr = it.addr;
          ins_pend = 1'b1;
        end
      end
    end
    if (!dat_pend) begin
      dat_rd_req = 1'b0;
      dat_wr_req = 1'b0;
      if (dat_script.size() > 0) begin
        d = dat_script.pop_front();
        dat_addr  = d.addr;
        dat_wdata = d.data;
        dat_rd_req = (d.op == 1) || (d.op == 3);
        dat_wr_req = (d.op == 2) || (d.op == 3);
        if (d.op != 0) dat_pend = 1'b1;
      end
    end
  end

  // Reference model: grant by priority list, plain integer counters.
  int m_starve = 0;
  int m_stall  = 0;
  bit m_err    = 0;

  always @(negedge clk) begin
    int   win;  // 0 none, 1 fetch, 2 data read, 3 data write
    logic [15:0] ea, ew;
    exp_t e;
    win = 0;
    if (reset_n) begin
      if (ins_req && m_starve == SMAX) win = 1;
      else if (dat_wr_req)             win = 3;
      else if (dat_rd_req)             win = 2;
      else if (ins_req)                win = 1;
    end
    ea = (win == 1) ? ins_addr : (win >= 2) ? dat_addr : 16'h0000;
    ew = (win == 3) ? dat_wdata : 16'h0000;
    check("mem_bus", {30'd0, mem_en, mem_we, mem_addr, mem_wdata},
          {30'd0, win != 0, win == 3, ea, ew});
    check("ins_stall_cnt", {48'd0, ins_stall_cnt}, 64'(m_stall));
    check("err_dual_req", {63'd0, err_dual_req}, {63'd0, m_err});
    e.cyc = cyc + 1;
    case (win)
      1: begin e.data = shadow[ins_addr]; exp_q[0].push_back(e); ins_pend = 1'b0; end
      2: begin e.data = shadow[dat_addr]; exp_q[1].push_back(e); dat_pend = 1'b0; end
      3: begin
        shadow[dat_addr] = dat_wdata;
        e.data = 16'h0000;
        exp_q[2].push_back(e);
        dat_pend = 1'b0;
      end
      default: ;
    endcase
    if (!reset_n) begin
      m_starve = 0;
      m_stall  = 0;
      m_err    = 0;
    end else begin
      if (ins_req && win != 1) begin
        if (m_starve < SMAX) m_starve++;
        if (m_stall < 65535) m_stall++;
      end else begin
        m_starve = 0;
      end
      if (dat_rd_req && dat_wr_req) m_err = 1;
    end
  end

  // Monitor: every rdy pulse must match the oldest expected return for that port.
  always @(negedge clk) begin
    logic [2:0]  rdy;
    logic [15:0] rdv [3];
    exp_t e;
    rdy    = {dat_wr_rdy, dat_rd_rdy, ins_rdy};
    rdv[0] = ins_rdata;
    rdv[1] = dat_rdata;
    rdv[2] = 16'h0000;
    for (int p = 0; p < 3; p++) begin
      if (rdy[p]) begin
        if (exp_q[p].size() == 0 || exp_q[p][0].cyc != cyc) begin
          checks++;
          errors++;
          $display("FAIL rdy_unexpected port=%0d actual=1 required=0 cyc=%0d", p, cyc);
        end else begin
          e = exp_q[p].pop_front();
          check($sformatf("rdata_port%0d", p), {48'd0, rdv[p]}, {48'd0, e.data});
        end
      end else begin
        if (exp_q[p].size() > 0 && exp_q[p][0].cyc <= cyc) begin
          e = exp_q[p].pop_front();
          checks++;
          errors++;
          $display("FAIL rdy_missing port=%0d actual=0 required=1 cyc=%0d", p, e.cyc);
        end
        if (p < 2) check($sformatf("rdata_idle_port%0d", p), {48'd0, rdv[p]}, 64'd0);
      end
    end
  end

  // Saturation model for the STARVE_MAX=15 instance: data read always pending.
  int s_starve = 0;
  int s_stall  = 0;
  int s_n      = 0;
  int s_hold   = 0;
  bit sat_done = 0;

  always @(negedge clk) begin
    s_n++;
    if (s_n % 512 == 0 || s_stall >= 65530) begin
      check("sat_stall_cnt", {48'd0, s_stall_cnt}, 64'(s_stall));
      check("sat_mem_addr", {48'd0, s_mem_addr},
            !sat_rst_n ? 64'd0 : (s_starve == SAT_SMAX) ? 64'd1 : 64'd2);
    end
    if (!sat_rst_n) begin
      s_starve = 0;
      s_stall  = 0;
    end else if (s_starve == SAT_SMAX) begin
      s_starve = 0;
    end else begin
      s_starve++;
      if (s_stall < 65535) s_stall++;
    end
    if (s_stall == 65535 && !sat_done) begin
      s_hold++;
      if (s_hold == 300) begin
        check("sat_final_ffff", {48'd0, s_stall_cnt}, 64'h0000_0000_0000_FFFF);
        sat_done = 1'b1;
      end
    end
  end

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((ins_script.size() > 0 || dat_script.size() > 0 || ins_pend || dat_pend ||
            exp_q[0].size() > 0 || exp_q[1].size() > 0 || exp_q[2].size() > 0) &&
           n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) fail_now(name);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    reset_n    = 1'b0;
    sat_rst_n  = 1'b0;
    ins_req    = 1'b0;
    dat_rd_req = 1'b0;
    dat_wr_req = 1'b0;
    ins_addr   = '0;
    dat_addr   = '0;
    dat_wdata  = '0;
    mem_rdata  = '0;
    for (int i = 0; i < 65536; i++) begin
      sram[i]   = 16'($urandom);
      shadow[i] = sram[i];
    end
    sram[0] = 16'h1111; shadow[0] = 16'h1111;
    sram[1] = 16'h2222; shadow[1] = 16'h2222;
    sram[2] = 16'h3333; shadow[2] = 16'h3333;
    repeat (3) @(posedge clk);
    #2;
    reset_n   = 1'b1;
    sat_rst_n = 1'b1;
    @(negedge clk);

    // Fetch-only stream over preloaded words.
    for (int i = 0; i < 3; i++) ins_script.push_back('{1'b0, 16'(i)});
    drain("drain_fetch", 100);
    check("fetch_stall_zero", {48'd0, ins_stall_cnt}, 64'd0);

    // Write/fetch conflict, then read back the written word.
    ins_script.push_back('{1'b0, 16'h0010});
    dat_script.push_back('{2, 16'h0020, 16'hBEEF});
    dat_script.push_back('{0, 16'h0000, 16'h0000});
    dat_script.push_back('{1, 16'h0020, 16'h0000});
    drain("drain_conflict", 100);
    check("conflict_stall_one", {48'd0, ins_stall_cnt}, 64'd1);

    // Starvation: continuous reads against continuous fetches.
    for (int i = 0; i < 20; i++) begin
      dat_script.push_back('{1, 16'(i + 64), 16'h0000});
      ins_script.push_back('{1'b0, 16'(i + 256)});
    end
    drain("drain_starve", 200);
    check("starve_stall_total", {48'd0, ins_stall_cnt}, 64'd21);

    // Dual data request: write wins, error flag sticks.
    dat_script.push_back('{3, 16'h0005, 16'h00AA});
    dat_script.push_back('{1, 16'h0005, 16'h0000});
    drain("drain_dual", 100);
    check("dual_err_set", {63'd0, err_dual_req}, 64'd1);
    repeat (5) @(negedge clk);
    check("dual_err_sticky", {63'd0, err_dual_req}, 64'd1);

    // Reset right after a fetch grant; a new fetch waits through reset.
    ins_script.push_back('{1'b0, 16'h0030});
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    ins_script.push_back('{1'b0, 16'h0031});
    @(posedge clk);
    @(negedge clk);
    check("reset_stall_zero", {48'd0, ins_stall_cnt}, 64'd0);
    check("reset_err_zero", {63'd0, err_dual_req}, 64'd0);
    check("reset_mem_en", {62'd0, mem_en, mem_we}, 64'd0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    drain("drain_reset", 100);

    // Random mix of fetches, reads, writes and dual requests.
    for (int i = 0; i < 300; i++) begin
      int r;
      ins_script.push_back('{($urandom_range(0, 2) == 0), 16'($urandom_range(0, 31))});
      r = $urandom_range(0, 9);
      dat_script.push_back('{(r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3,
                             16'($urandom_range(0, 31)), 16'($urandom)});
    end
    drain("drain_random", 5000);

    n = 0;
    while (!sat_done && n < 80000) begin
      @(negedge clk);
      n++;
    end
    if (!sat_done) fail_now("sat_wait");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
